route_lookup_dispatcher: RTL and testbench

Front-end for the routing system's auto two-level lookup port A. It accepts forwarding descriptors `(src_sw, dst_host, tag)` over a valid/ready stream and issues one lookup per cycle into the fixed-latency, non-backpressurable port A pipeline. Returned path results are matched in order to their tags and delivered on a buffered valid/ready output stream. A credit scheme guarantees that no response is ever dropped.

---
 rtl/route_lookup_pkg.sv | 19 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/route_lookup_dispatcher.sv | 180 ++++++++++++++++++
 tb/tb_route_lookup_dispatcher.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/route_lookup_pkg.sv
// Shared types and widths for the port A route lookup front-end.
// A route result is 145 bits: hit flag plus six path fields.
package route_lookup_pkg;

    localparam int SW_IDX_W   = 4;
    localparam int HOST_IDX_W = 6;
    localparam int RESULT_W   = 145;

    typedef struct packed {
        logic        path_valid;
        logic [15:0] out_port;
        logic [15:0] out_qp;
        logic [31:0] nh_ip;
        logic [15:0] nh_port;
        logic [15:0] nh_qp;
        logic [47:0] nh_mac;
    } route_result_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with an occupancy count.
// Pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (count != CW'(DEPTH));
    assign do_pop   = pop && (count != '0);
    assign pop_data = mem[rd_ptr];

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/route_lookup_dispatcher.sv
// Issues route lookups into fixed-latency port A and returns results in tag order.
// Credits cover both queues, so every response has a guaranteed result slot.
module route_lookup_dispatcher
    import route_lookup_pkg::*;
#(
    parameter int TAG_W      = 8,
    parameter int OUT_DEPTH  = 8,
    parameter int LOOKUP_LAT = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  system_ready,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SW_IDX_W-1:0]   in_src_sw,
    input  logic [HOST_IDX_W-1:0] in_dst_host,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  req_a_valid,
    output logic [SW_IDX_W-1:0]   req_a_src_sw,
    output logic [HOST_IDX_W-1:0] req_a_dst_host,
    input  logic                  resp_a_valid,
    input  logic                  resp_a_path_valid,
    input  logic [15:0]           resp_a_path_out_port,
    input  logic [15:0]           resp_a_path_out_qp,
    input  logic [31:0]           resp_a_path_next_hop_ip,
    input  logic [15:0]           resp_a_path_next_hop_port,
    input  logic [15:0]           resp_a_path_next_hop_qp,
    input  logic [47:0]           resp_a_path_next_hop_mac,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_path_valid,
    output logic [15:0]           out_port,
    output logic [15:0]           out_qp,
    output logic [31:0]           out_nh_ip,
    output logic [15:0]           out_nh_port,
    output logic [15:0]           out_nh_qp,
    output logic [47:0]           out_nh_mac,
    output logic [15:0]           miss_cnt,
    output logic                  err_orphan,
    output logic                  err_timeout
);

    localparam int CNT_W   = $clog2(OUT_DEPTH) + 1;
    localparam int AGE_MAX = 2 * LOOKUP_LAT;
    localparam int AGE_W   = $clog2(AGE_MAX + 1);
    localparam int BLANK_W = $clog2(LOOKUP_LAT + 2);
    localparam int ENTRY_W = TAG_W + RESULT_W;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        route_result_t    res;
    } entry_t;

    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   res_count;
    logic [CNT_W-1:0]   reserved;
    logic [BLANK_W-1:0] blank_cnt;
    logic [AGE_W-1:0]   age;
    logic [AGE_W-1:0]   age_next;
    logic [TAG_W-1:0]   tag_head;
    logic [ENTRY_W-1:0] res_head_bits;
    entry_t             res_push;
    entry_t             res_head;
    entry_t             shown;
    route_result_t      resp_res;
    logic               blank;
    logic               accept;
    logic               resp_take;
    logic               resp_orphan;
    logic               out_pop;

    assign blank       = (blank_cnt != '0);
    assign in_ready    = system_ready && !blank && (reserved < CNT_W'(OUT_DEPTH));
    assign accept      = in_valid && in_ready;
    assign resp_take   = resp_a_valid && !blank && (outstanding != '0);
    assign resp_orphan = resp_a_valid && !blank && (outstanding == '0);
    assign out_valid   = (res_count != '0);
    assign out_pop     = out_valid && out_ready;

    assign resp_res = '{
        path_valid: resp_a_path_valid,
        out_port:   resp_a_path_out_port,
        out_qp:     resp_a_path_out_qp,
        nh_ip:      resp_a_path_next_hop_ip,
        nh_port:    resp_a_path_next_hop_port,
        nh_qp:      resp_a_path_next_hop_qp,
        nh_mac:     resp_a_path_next_hop_mac
    };
    assign res_push = '{tag: tag_head, res: resp_res};

    sync_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (OUT_DEPTH)
    ) u_tag_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (in_tag),
        .pop       (resp_take),
        .pop_data  (tag_head),
        .count     (outstanding)
    );

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (OUT_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (resp_take),
        .push_data (res_push),
        .pop       (out_pop),
        .pop_data  (res_head_bits),
        .count     (res_count)
    );

    // Outputs read as zero whenever the result FIFO holds nothing.
    assign res_head       = entry_t'(res_head_bits);
    assign shown          = out_valid ? res_head : '0;
    assign out_tag        = shown.tag;
    assign out_path_valid = shown.res.path_valid;
    assign out_port       = shown.res.out_port;
    assign out_qp         = shown.res.out_qp;
    assign out_nh_ip      = shown.res.nh_ip;
    assign out_nh_port    = shown.res.nh_port;
    assign out_nh_qp      = shown.res.nh_qp;
    assign out_nh_mac     = shown.res.nh_mac;

    // Age of the oldest outstanding request; restarts when it is answered.
    always_comb begin
        age_next = age;
        if (resp_take || (accept && outstanding == '0)) begin
            age_next = '0;
        end else if (outstanding == '0) begin
            age_next = '0;
        end else if (age != AGE_W'(AGE_MAX)) begin
            age_next = age + AGE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reserved       <= '0;
            blank_cnt      <= BLANK_W'(LOOKUP_LAT + 1);
            age            <= '0;
            miss_cnt       <= '0;
            err_orphan     <= 1'b0;
            err_timeout    <= 1'b0;
            req_a_valid    <= 1'b0;
            req_a_src_sw   <= '0;
            req_a_dst_host <= '0;
        end else begin
            case ({accept, out_pop})
                2'b10:   reserved <= reserved + CNT_W'(1);
                2'b01:   reserved <= reserved - CNT_W'(1);
                default: reserved <= reserved;
            endcase
            if (blank) begin
                blank_cnt <= blank_cnt - BLANK_W'(1);
            end
            age <= age_next;
            if (age_next == AGE_W'(AGE_MAX)) begin
                err_timeout <= 1'b1;
            end
            if (resp_take && !resp_a_path_valid && miss_cnt != 16'hFFFF) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
            if (resp_orphan) begin
                err_orphan <= 1'b1;
            end
            req_a_valid <= accept;
            if (accept) begin
                req_a_src_sw   <= in_src_sw;
                req_a_dst_host <= in_dst_host;
            end
        end
    end

endmodule

// File: tb/tb_route_lookup_dispatcher.sv
// Directed bench: a fixed-latency port A model answers every issued key,
// and results are compared against hand-computed table entries and sequences.
module tb_route_lookup_dispatcher;
    import route_lookup_pkg::*;

    localparam int TAG_W = 8;
    localparam int DEPTH = 8;
    localparam int LAT   = 5;

    logic        clk;
    logic        rst;
    logic        system_ready;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_src_sw;
    logic [5:0]  in_dst_host;
    logic [7:0]  in_tag;
    logic        req_a_valid;
    logic [3:0]  req_a_src_sw;
    logic [5:0]  req_a_dst_host;
    logic        resp_a_valid;
    logic        resp_a_path_valid;
    logic [15:0] resp_a_path_out_port;
    logic [15:0] resp_a_path_out_qp;
    logic [31:0] resp_a_path_next_hop_ip;
    logic [15:0] resp_a_path_next_hop_port;
    logic [15:0] resp_a_path_next_hop_qp;
    logic [47:0] resp_a_path_next_hop_mac;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_tag;
    logic        out_path_valid;
    logic [15:0] out_port;
    logic [15:0] out_qp;
    logic [31:0] out_nh_ip;
    logic [15:0] out_nh_port;
    logic [15:0] out_nh_qp;
    logic [47:0] out_nh_mac;
    logic [15:0] miss_cnt;
    logic        err_orphan;
    logic        err_timeout;

    route_lookup_dispatcher #(
        .TAG_W      (TAG_W),
        .OUT_DEPTH  (DEPTH),
        .LOOKUP_LAT (LAT)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .system_ready              (system_ready),
        .in_valid                  (in_valid),
        .in_ready                  (in_ready),
        .in_src_sw                 (in_src_sw),
        .in_dst_host               (in_dst_host),
        .in_tag                    (in_tag),
        .req_a_valid               (req_a_valid),
        .req_a_src_sw              (req_a_src_sw),
        .req_a_dst_host            (req_a_dst_host),
        .resp_a_valid              (resp_a_valid),
        .resp_a_path_valid         (resp_a_path_valid),
        .resp_a_path_out_port      (resp_a_path_out_port),
        .resp_a_path_out_qp        (resp_a_path_out_qp),
        .resp_a_path_next_hop_ip   (resp_a_path_next_hop_ip),
        .resp_a_path_next_hop_port (resp_a_path_next_hop_port),
        .resp_a_path_next_hop_qp   (resp_a_path_next_hop_qp),
        .resp_a_path_next_hop_mac  (resp_a_path_next_hop_mac),
        .out_valid                 (out_valid),
        .out_ready                 (out_ready),
        .out_tag                   (out_tag),
        .out_path_valid            (out_path_valid),
        .out_port                  (out_port),
        .out_qp                    (out_qp),
        .out_nh_ip                 (out_nh_ip),
        .out_nh_port               (out_nh_port),
        .out_nh_qp                 (out_nh_qp),
        .out_nh_mac                (out_nh_mac),
        .miss_cnt                  (miss_cnt),
        .err_orphan                (err_orphan),
        .err_timeout               (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port A model: fixed latency, hit unless host 63; not affected by rst.
    typedef struct packed {
        logic       v;
        logic [3:0] sw;
        logic [5:0] host;
    } req_t;

    req_t pipe [LAT];
    req_t head;
    logic withhold;
    logic stray;
    int   req_cnt;

    initial begin
        for (int k = 0; k < LAT; k++) pipe[k] = '0;
    end

    always @(posedge clk) begin
        pipe[0] <= {req_a_valid && !withhold, req_a_src_sw, req_a_dst_host};
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        if (req_a_valid) req_cnt <= req_cnt + 1;
    end

    assign head                      = pipe[LAT-1];
    assign resp_a_valid              = head.v || stray;
    assign resp_a_path_valid         = (head.host != 6'd63);
    assign resp_a_path_out_port      = 16'(head.sw) * 16'd2 + 16'd1 + 16'(head.host) * 16'd4;
    assign resp_a_path_out_qp        = 16'd16 + 16'(head.sw) + 16'(head.host);
    assign resp_a_path_next_hop_ip   = {16'hC0A8, 2'b00, head.host, 4'h0, head.sw};
    assign resp_a_path_next_hop_port = 16'h1000 + 16'(head.sw);
    assign resp_a_path_next_hop_qp   = 16'h2000 + 16'(head.host);
    assign resp_a_path_next_hop_mac  = 48'h0200_0000_0000 | (48'(head.sw) + 48'd1);

    typedef struct {
        logic [7:0]  tag;
        logic        pv;
        logic [15:0] port;
        logic [15:0] qp;
        logic [31:0] ip;
        logic [15:0] nhp;
        logic [15:0] nhq;
        logic [47:0] mac;
    } obs_t;

    obs_t obs_q[$];

    // Record every completed output handshake, sampled mid-cycle.
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready) begin
            obs_q.push_back('{out_tag, out_path_valid, out_port, out_qp,
                              out_nh_ip, out_nh_port, out_nh_qp, out_nh_mac});
        end
    end

    typedef struct {
        logic [3:0]  sw;
        logic [5:0]  host;
        logic [7:0]  tag;
        logic        pv;
        logic [15:0] port;
        logic [15:0] qp;
        logic [31:0] ip;
        logic [15:0] nhp;
        logic [15:0] nhq;
        logic [47:0] mac;
    } vec_t;

    vec_t vecs [6];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [3:0] sw, input logic [5:0] host, input logic [7:0] tag);
        bit done;
        done        = 1'b0;
        in_valid    = 1'b1;
        in_src_sw   = sw;
        in_dst_host = host;
        in_tag      = tag;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            done = in_ready;
            @(posedge clk);
            @(negedge clk);
        end
        if (!done) checkOutput("accept_timeout", 64'(tag), 64'hFFFF);
    endtask

    task automatic waitObs(input int n, input string name);
        for (int c = 0; c < 80 && obs_q.size() < n; c++) begin
            @(negedge clk);
            #3;
        end
        checkOutput(name, 64'(obs_q.size()), 64'(n));
    endtask

    initial begin
        vecs[0] = '{4'd1,  6'd0,  8'h21, 1'b1, 16'd3,   16'd17, 32'hC0A8_0001, 16'h1001, 16'h2000, 48'h0200_0000_0002};
        vecs[1] = '{4'd2,  6'd1,  8'h42, 1'b1, 16'd9,   16'd19, 32'hC0A8_0102, 16'h1002, 16'h2001, 48'h0200_0000_0003};
        vecs[2] = '{4'd0,  6'd63, 8'h05, 1'b0, 16'd253, 16'd79, 32'hC0A8_3F00, 16'h1000, 16'h203F, 48'h0200_0000_0001};
        vecs[3] = '{4'd15, 6'd10, 8'h7E, 1'b1, 16'd71,  16'd41, 32'hC0A8_0A0F, 16'h100F, 16'h200A, 48'h0200_0000_0010};
        vecs[4] = '{4'd3,  6'd5,  8'h33, 1'b1, 16'd27,  16'd24, 32'hC0A8_0503, 16'h1003, 16'h2005, 48'h0200_0000_0004};
        vecs[5] = '{4'd7,  6'd2,  8'hA0, 1'b1, 16'd23,  16'd25, 32'hC0A8_0207, 16'h1007, 16'h2002, 48'h0200_0000_0008};

        rst = 1'b1; system_ready = 1'b1; in_valid = 1'b0; in_src_sw = '0;
        in_dst_host = '0; in_tag = '0; out_ready = 1'b1; withhold = 1'b0;
        stray = 1'b0; req_cnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_req_valid", 64'(req_a_valid), 64'd0);
        checkOutput("rst_req_key", 64'({req_a_src_sw, req_a_dst_host}), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_fields", 64'({out_tag, out_port, out_qp}), 64'd0);
        checkOutput("rst_miss_cnt", 64'(miss_cnt), 64'd0);
        checkOutput("rst_errors", 64'({err_orphan, err_timeout}), 64'd0);
        rst = 1'b0;
        for (int c = 0; c < 20 && !in_ready; c++) @(negedge clk);

        // Single hit with exact latency.
        obs_q.delete();
        in_valid = 1'b1; in_src_sw = 4'd1; in_dst_host = 6'd0; in_tag = 8'h21;
        #1;
        checkOutput("hit_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("hit_req_valid", 64'(req_a_valid), 64'd1);
        checkOutput("hit_req_key", 64'({req_a_src_sw, req_a_dst_host}), 64'({4'd1, 6'd0}));
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            if (k == 2) checkOutput("hit_req_pulse", 64'(req_a_valid), 64'd0);
            checkOutput($sformatf("hit_early_k%0d", k), 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        checkOutput("hit_out_valid", 64'(out_valid), 64'd1);
        checkOutput("hit_tag", 64'(out_tag), 64'h21);
        checkOutput("hit_port", 64'(out_port), 64'd3);
        checkOutput("hit_qp", 64'(out_qp), 64'd17);
        checkOutput("hit_mac", 64'(out_nh_mac), 64'h0200_0000_0002);
        repeat (2) @(negedge clk);

        // Table of back-to-back descriptors, including one miss.
        obs_q.delete();
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i].sw, vecs[i].host, vecs[i].tag);
        in_valid = 1'b0;
        waitObs(6, "tbl_count");
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            checkOutput($sformatf("tbl%0d_tag", i), 64'(obs_q[i].tag), 64'(vecs[i].tag));
            checkOutput($sformatf("tbl%0d_pv", i), 64'(obs_q[i].pv), 64'(vecs[i].pv));
            checkOutput($sformatf("tbl%0d_port", i), 64'(obs_q[i].port), 64'(vecs[i].port));
            checkOutput($sformatf("tbl%0d_qp", i), 64'(obs_q[i].qp), 64'(vecs[i].qp));
            checkOutput($sformatf("tbl%0d_ip", i), 64'(obs_q[i].ip), 64'(vecs[i].ip));
            checkOutput($sformatf("tbl%0d_nhp", i), 64'(obs_q[i].nhp), 64'(vecs[i].nhp));
            checkOutput($sformatf("tbl%0d_nhq", i), 64'(obs_q[i].nhq), 64'(vecs[i].nhq));
            checkOutput($sformatf("tbl%0d_mac", i), 64'(obs_q[i].mac), 64'(vecs[i].mac));
        end
        checkOutput("miss_cnt_one", 64'(miss_cnt), 64'd1);

        // Backpressure: only DEPTH credits with the output stalled.
        @(negedge clk);
        obs_q.delete();
        out_ready = 1'b0;
        req_cnt   = 0;
        begin
            int nxt;
            bit got;
            nxt = 0;
            for (int c = 0; c < 20; c++) begin
                in_valid    = (nxt < 10);
                in_tag      = 8'(nxt);
                in_src_sw   = 4'(nxt);
                in_dst_host = 6'(nxt + 1);
                #1;
                got = in_valid && in_ready;
                @(posedge clk);
                if (got) nxt++;
                @(negedge clk);
            end
            checkOutput("bp_accepts", 64'(nxt), 64'd8);
            checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
            checkOutput("bp_req_count", 64'(req_cnt), 64'd8);
            checkOutput("bp_no_output", 64'(obs_q.size()), 64'd0);
            out_ready = 1'b1;
            #1;
            checkOutput("bp_ready_before_pop", 64'(in_ready), 64'd0);
            @(negedge clk);
            #1;
            checkOutput("bp_ready_after_pop", 64'(in_ready), 64'd1);
            for (int c = 0; c < 40 && nxt < 10; c++) begin
                in_valid    = 1'b1;
                in_tag      = 8'(nxt);
                in_src_sw   = 4'(nxt);
                in_dst_host = 6'(nxt + 1);
                #1;
                got = in_ready;
                @(posedge clk);
                if (got) nxt++;
                @(negedge clk);
            end
            in_valid = 1'b0;
        end
        waitObs(10, "bp_count");
        for (int i = 0; i < 10 && i < obs_q.size(); i++) begin
            checkOutput($sformatf("bp%0d_tag", i), 64'(obs_q[i].tag), 64'(i));
        end
        checkOutput("bp_miss_cnt", 64'(miss_cnt), 64'd1);

        // Stray response with nothing outstanding.
        repeat (2) @(negedge clk);
        obs_q.delete();
        checkOutput("orphan_before", 64'(err_orphan), 64'd0);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        checkOutput("orphan_set", 64'(err_orphan), 64'd1);
        repeat (3) @(negedge clk);
        #3;
        checkOutput("orphan_no_output", 64'(obs_q.size()), 64'd0);
        checkOutput("orphan_out_valid", 64'(out_valid), 64'd0);

        // Withheld response: timeout ten cycles after issue.
        withhold = 1'b1;
        checkOutput("timeout_before", 64'(err_timeout), 64'd0);
        applyStimulus(4'd1, 6'd1, 8'h77);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("timeout_at_9", 64'(err_timeout), 64'd0);
        @(negedge clk);
        checkOutput("timeout_at_10", 64'(err_timeout), 64'd1);
        withhold = 1'b0;

        // Reset with three lookups in flight; their responses must vanish.
        obs_q.delete();
        applyStimulus(4'd2, 6'd3, 8'hB1);
        applyStimulus(4'd4, 6'd5, 8'hB2);
        applyStimulus(4'd6, 6'd7, 8'hB3);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            checkOutput($sformatf("blank_in_ready_c%0d", c), 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        checkOutput("blank_in_ready_c7", 64'(in_ready), 64'd1);
        #3;
        checkOutput("blank_no_output", 64'(obs_q.size()), 64'd0);
        checkOutput("blank_out_valid", 64'(out_valid), 64'd0);
        checkOutput("blank_no_orphan", 64'(err_orphan), 64'd0);
        checkOutput("blank_timeout_cleared", 64'(err_timeout), 64'd0);
        checkOutput("blank_miss_cleared", 64'(miss_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
